// File: rtl/tmnt_layer_mixer_if.sv
// ---------------------------------------------------------------------------
// tmnt_layer_mixer_if
//   Bundles the signals of the layer mixer that are not the clock or the reset.
//
//   CPU side : PRIOCS, NLWR, NREAD (active-low), CPU_DIN[7:0], CPU_DOUT[7:0]
//   Video    : NHBLK, NVBLK (active-low blanks)
//   Pixels   : FIX_PIX, LYRA_PIX, LYRB_PIX = {pal[2:0], col[3:0]}
//              OBJ_PIX = {pal[3:0], col[3:0]}, OBJ_PRI, OBJ_SHADOW
//   Results  : CD[9:0] = {src[1:0], pal[3:0], col[3:0]}, SHADOW, NCBLK
//
//   master : drives the CPU bus and the pixel inputs (board / testbench)
//   slave  : the mixer itself
// ---------------------------------------------------------------------------
interface tmnt_layer_mixer_if;
    logic       PRIOCS;
    logic       NLWR;
    logic       NREAD;
    logic [7:0] CPU_DIN;
    logic [7:0] CPU_DOUT;
    logic       NHBLK;
    logic       NVBLK;
    logic [6:0] FIX_PIX;
    logic [6:0] LYRA_PIX;
    logic [6:0] LYRB_PIX;
    logic [7:0] OBJ_PIX;
    logic       OBJ_PRI;
    logic       OBJ_SHADOW;
    logic [9:0] CD;
    logic       SHADOW;
    logic       NCBLK;

    modport master (
        output PRIOCS, NLWR, NREAD, CPU_DIN,
        output NHBLK, NVBLK,
        output FIX_PIX, LYRA_PIX, LYRB_PIX, OBJ_PIX, OBJ_PRI, OBJ_SHADOW,
        input  CPU_DOUT, CD, SHADOW, NCBLK
    );

    modport slave (
        input  PRIOCS, NLWR, NREAD, CPU_DIN,
        input  NHBLK, NVBLK,
        input  FIX_PIX, LYRA_PIX, LYRB_PIX, OBJ_PIX, OBJ_PRI, OBJ_SHADOW,
        output CPU_DOUT, CD, SHADOW, NCBLK
    );
endinterface

// File: rtl/tmnt_layer_mixer.sv
// ---------------------------------------------------------------------------
// tmnt_layer_mixer
//   Priority mixer in front of the palette stage. Resolves fix / tile A /
//   tile B / sprite priority and sprite shadow, producing the palette index
//   CD, the SHADOW flag and the composite blank NCBLK.
//
//   Ports:
//     V6M    - pixel clock, rising edge
//     NRESET - asynchronous active-low reset
//     bus    - tmnt_layer_mixer_if.slave (CPU bus, blanks, pixels, results)
//
//   The CPU writes a pending priority byte at any time; it becomes active on
//   the falling edge of NVBLK so a frame is never mixed with two modes.
//   Active byte: [0] swap A/B, [1] sprite low-priority enable,
//                [2] shadow enable, [3] fix disable, [7:4] stored only.
//   Pixel path is two registers deep: input capture, then the mixed result.
// ---------------------------------------------------------------------------
module tmnt_layer_mixer (
    input  logic                 V6M,
    input  logic                 NRESET,
    tmnt_layer_mixer_if.slave    bus
);

    typedef enum logic [1:0] {
        SRC_FIX = 2'b00,
        SRC_A   = 2'b01,
        SRC_B   = 2'b10,
        SRC_OBJ = 2'b11
    } src_e;

    // -----------------------------------------------------------------------
    // Priority register: pending (CPU side) and active (video side)
    // -----------------------------------------------------------------------
    logic [7:0] pend;
    logic [7:0] act;
    logic       nvblk_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; this is what lets act take the old pend
    // even when a CPU write lands in pend on the same edge.
    always_ff @(posedge V6M or negedge NRESET) begin
        if (!NRESET) begin
            pend    <= 8'h00;
            act     <= 8'h00;
            nvblk_d <= 1'b0;
        end else begin
            nvblk_d <= bus.NVBLK;
            if (!bus.PRIOCS && !bus.NLWR)
                pend <= bus.CPU_DIN;
            // nvblk_d resets low, so leaving reset with NVBLK low is no edge
            if (nvblk_d && !bus.NVBLK)
                act <= pend;
        end
    end

    assign bus.CPU_DOUT = (!bus.PRIOCS && !bus.NREAD) ? act : 8'h00;

    // -----------------------------------------------------------------------
    // Stage 1: capture pixels and the combined blank
    // -----------------------------------------------------------------------
    logic [6:0] s1_fix;
    logic [6:0] s1_lyra;
    logic [6:0] s1_lyrb;
    logic [7:0] s1_obj;
    logic       s1_obj_pri;
    logic       s1_obj_shadow;
    logic       s1_blank_n;

    always_ff @(posedge V6M or negedge NRESET) begin
        if (!NRESET) begin
            s1_fix        <= 7'h00;
            s1_lyra       <= 7'h00;
            s1_lyrb       <= 7'h00;
            s1_obj        <= 8'h00;
            s1_obj_pri    <= 1'b0;
            s1_obj_shadow <= 1'b0;
            s1_blank_n    <= 1'b0;
        end else begin
            s1_fix        <= bus.FIX_PIX;
            s1_lyra       <= bus.LYRA_PIX;
            s1_lyrb       <= bus.LYRB_PIX;
            s1_obj        <= bus.OBJ_PIX;
            s1_obj_pri    <= bus.OBJ_PRI;
            s1_obj_shadow <= bus.OBJ_SHADOW;
            s1_blank_n    <= bus.NHBLK & bus.NVBLK;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: priority resolve
    // -----------------------------------------------------------------------
    logic       swap;
    logic       objpri_en;
    logic       shadow_en;
    logic       fix_dis;

    assign swap      = act[0];
    assign objpri_en = act[1];
    assign shadow_en = act[2];
    assign fix_dis   = act[3];

    logic [9:0] fix_cd;
    logic [9:0] front_cd;
    logic [9:0] back_cd;
    logic [9:0] obj_cd;
    logic       fix_op;
    logic       front_op;
    logic       obj_op;
    logic       obj_vis;     // opaque ordinary sprite, can be selected
    logic       obj_shd;     // opaque shadow sprite with shadowing enabled
    logic       obj_low;

    assign fix_cd = {SRC_FIX, 1'b0, s1_fix};
    assign obj_cd = {SRC_OBJ, s1_obj};

    // Tile palettes are 3 bits; the extra zero widens them to the 4-bit field.
    assign front_cd = swap ? {SRC_B, 1'b0, s1_lyrb} : {SRC_A, 1'b0, s1_lyra};
    assign back_cd  = swap ? {SRC_A, 1'b0, s1_lyra} : {SRC_B, 1'b0, s1_lyrb};

    assign fix_op   = (s1_fix[3:0] != 4'h0) && !fix_dis;
    assign front_op = (front_cd[3:0] != 4'h0);
    assign obj_op   = (s1_obj[3:0] != 4'h0);
    // With shadowing disabled a shadow sprite simply vanishes.
    assign obj_vis  = obj_op && !s1_obj_shadow;
    assign obj_shd  = obj_op && s1_obj_shadow && shadow_en;
    assign obj_low  = objpri_en && s1_obj_pri;

    // The back layer is the last resort: a transparent back pixel already has
    // col = 0, which is exactly the backdrop encoding {src, pal, 4'h0}.
    logic [9:0] cd_nxt;
    logic       shadow_nxt;

    // NOTE: outputs are given defaults first so no path leaves them unassigned
    // (otherwise the tool infers latches for the combinational result).
    always_comb begin
        cd_nxt     = 10'h000;
        shadow_nxt = 1'b0;
        if (!s1_blank_n) begin
            cd_nxt     = 10'h000;
            shadow_nxt = 1'b0;
        end else if (fix_op) begin
            cd_nxt = fix_cd;
        end else if (obj_low) begin
            if (front_op) begin
                cd_nxt = front_cd;
            end else if (obj_vis) begin
                cd_nxt = obj_cd;
            end else begin
                shadow_nxt = obj_shd;
                cd_nxt     = back_cd;
            end
        end else begin
            if (obj_vis) begin
                cd_nxt = obj_cd;
            end else begin
                // A shadow sprite at the top rank darkens whatever is beneath.
                shadow_nxt = obj_shd;
                cd_nxt     = front_op ? front_cd : back_cd;
            end
        end
    end

    logic [9:0] cd_q;
    logic       shadow_q;
    logic       ncblk_q;

    always_ff @(posedge V6M or negedge NRESET) begin
        if (!NRESET) begin
            cd_q     <= 10'h000;
            shadow_q <= 1'b0;
            ncblk_q  <= 1'b0;
        end else begin
            cd_q     <= cd_nxt;
            shadow_q <= shadow_nxt;
            ncblk_q  <= s1_blank_n;
        end
    end

    assign bus.CD     = cd_q;
    assign bus.SHADOW = shadow_q;
    assign bus.NCBLK  = ncblk_q;

endmodule

// File: tb/tb_tmnt_layer_mixer.sv
// ---------------------------------------------------------------------------
// tb_tmnt_layer_mixer
//   Self-checking bench for tmnt_layer_mixer. Each driven pixel pushes its
//   expected {CD, SHADOW, NCBLK} into a queue; two clocks later the entry is
//   popped and compared with the outputs. Scenario tasks add direct checks.
// ---------------------------------------------------------------------------
module tb_tmnt_layer_mixer;

    typedef struct packed {
        logic [6:0] fix;
        logic [6:0] a;
        logic [6:0] b;
        logic [7:0] obj;
        logic       pri;
        logic       osh;
        logic       nhblk;
        logic       nvblk;
    } pix_t;

    logic V6M;
    logic NRESET;

    tmnt_layer_mixer_if bus ();

    tmnt_layer_mixer dut (
        .V6M    (V6M),
        .NRESET (NRESET),
        .bus    (bus)
    );

    initial V6M = 1'b0;
    always #5 V6M = ~V6M;

    int total = 0;
    int bad   = 0;

    logic [11:0] sb [$];
    logic [7:0]  m_pend;
    logic [7:0]  m_act;
    logic        m_nvd;

    function automatic pix_t mkpix(input logic [6:0] fix, input logic [6:0] a,
                                   input logic [6:0] b, input logic [7:0] obj,
                                   input logic pri, input logic osh,
                                   input logic nhblk, input logic nvblk);
        pix_t p;
        p.fix = fix; p.a = a; p.b = b; p.obj = obj;
        p.pri = pri; p.osh = osh; p.nhblk = nhblk; p.nvblk = nvblk;
        return p;
    endfunction

    // Reference: walk an ordered candidate list; the first opaque ordinary
    // candidate wins, an opaque shadow candidate met on the way sets shadow.
    function automatic logic [11:0] model_pix(input logic [7:0] a, input pix_t p);
        logic [9:0] cand [4];
        logic       opq  [4];
        logic       shd  [4];
        logic [9:0] fr, bk, ob;
        logic       ob_op, hit, done;
        logic [9:0] res;
        if (a[0]) begin
            fr = {2'b10, 1'b0, p.b}; bk = {2'b01, 1'b0, p.a};
        end else begin
            fr = {2'b01, 1'b0, p.a}; bk = {2'b10, 1'b0, p.b};
        end
        ob    = {2'b11, p.obj};
        ob_op = (p.obj[3:0] != 4'h0) && !(p.osh && !a[2]);
        cand[0] = {3'b000, p.fix}; opq[0] = (p.fix[3:0] != 4'h0) && !a[3]; shd[0] = 1'b0;
        if (a[1] && p.pri) begin
            cand[1] = fr; opq[1] = (fr[3:0] != 4'h0); shd[1] = 1'b0;
            cand[2] = ob; opq[2] = ob_op;             shd[2] = p.osh;
        end else begin
            cand[1] = ob; opq[1] = ob_op;             shd[1] = p.osh;
            cand[2] = fr; opq[2] = (fr[3:0] != 4'h0); shd[2] = 1'b0;
        end
        cand[3] = bk; opq[3] = 1'b1; shd[3] = 1'b0;
        hit = 1'b0; done = 1'b0; res = 10'h000;
        for (int i = 0; i < 4; i++) begin
            if (!done && opq[i]) begin
                if (shd[i]) hit = 1'b1;
                else begin res = cand[i]; done = 1'b1; end
            end
        end
        if (!(p.nhblk && p.nvblk)) return 12'h000;
        return {res, hit, 1'b1};
    endfunction

    // One pixel clock: check the output due now, drive, check readback,
    // advance the reference state and queue the expected pixel result.
    task automatic step(input pix_t p, input logic wr, input logic [7:0] din,
                        input logic rd);
        logic [11:0] e;
        logic [7:0]  ed;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            total++;
            if ({bus.CD, bus.SHADOW, bus.NCBLK} !== e) begin
                bad++;
                $display("FAIL pixel: got cd=%h sh=%b ncblk=%b, want cd=%h sh=%b ncblk=%b",
                         bus.CD, bus.SHADOW, bus.NCBLK, e[11:2], e[1], e[0]);
            end
        end
        bus.FIX_PIX    = p.fix;
        bus.LYRA_PIX   = p.a;
        bus.LYRB_PIX   = p.b;
        bus.OBJ_PIX    = p.obj;
        bus.OBJ_PRI    = p.pri;
        bus.OBJ_SHADOW = p.osh;
        bus.NHBLK      = p.nhblk;
        bus.NVBLK      = p.nvblk;
        bus.PRIOCS     = !(wr || rd);
        bus.NLWR       = !wr;
        bus.NREAD      = !rd;
        bus.CPU_DIN    = din;
        #1;
        ed = rd ? m_act : 8'h00;
        total++;
        if (bus.CPU_DOUT !== ed) begin
            bad++;
            $display("FAIL readback: got %h, want %h", bus.CPU_DOUT, ed);
        end
        if (m_nvd && !p.nvblk) m_act = m_pend;
        if (wr) m_pend = din;
        m_nvd = p.nvblk;
        sb.push_back(model_pix(m_act, p));
        @(posedge V6M);
        @(negedge V6M);
    endtask

    task automatic vblank(input pix_t p);
        pix_t q;
        q = p;
        q.nvblk = 1'b0;
        for (int i = 0; i < 3; i++) step(q, 1'b0, 8'h00, 1'b1);
        q.nvblk = 1'b1;
        step(q, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic model_reset();
        sb.delete();
        m_pend = 8'h00;
        m_act  = 8'h00;
        m_nvd  = 1'b0;
    endtask

    task automatic test_reset();
        NRESET = 1'b0;
        bus.FIX_PIX = 7'h7F; bus.LYRA_PIX = 7'h15; bus.LYRB_PIX = 7'h2A;
        bus.OBJ_PIX = 8'h93; bus.OBJ_PRI = 1'b0; bus.OBJ_SHADOW = 1'b0;
        bus.NHBLK = 1'b1; bus.NVBLK = 1'b1;
        bus.PRIOCS = 1'b0; bus.NLWR = 1'b1; bus.NREAD = 1'b0; bus.CPU_DIN = 8'hFF;
        model_reset();
        repeat (3) @(negedge V6M);
        total++;
        if ({bus.CD, bus.SHADOW, bus.NCBLK} !== 12'h000) begin
            bad++;
            $display("FAIL reset_out: got cd=%h sh=%b ncblk=%b, want 0", bus.CD, bus.SHADOW, bus.NCBLK);
        end
        total++;
        if (bus.CPU_DOUT !== 8'h00) begin
            bad++;
            $display("FAIL reset_dout: got %h, want 00", bus.CPU_DOUT);
        end
        NRESET = 1'b1;
    endtask

    task automatic test_basic();
        pix_t p;
        p = mkpix(7'h00, 7'h15, 7'h2A, 8'h93, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(p, 1'b0, 8'h00, 1'b1);
        total++;
        if (bus.CD !== 10'h393) begin
            bad++;
            $display("FAIL basic_cd: got %h, want 393", bus.CD);
        end
    endtask

    task automatic test_apply();
        pix_t p;
        p = mkpix(7'h00, 7'h15, 7'h2A, 8'h90, 1'b0, 1'b0, 1'b1, 1'b1);
        step(p, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) step(p, 1'b0, 8'h00, 1'b1);
        total++;
        if (bus.CD !== 10'h115) begin
            bad++;
            $display("FAIL apply_before: got %h, want 115", bus.CD);
        end
        vblank(p);
        for (int i = 0; i < 3; i++) step(p, 1'b0, 8'h00, 1'b1);
        total++;
        if (bus.CD !== 10'h22A) begin
            bad++;
            $display("FAIL apply_after: got %h, want 22A", bus.CD);
        end
    endtask

    task automatic test_objpri();
        pix_t p;
        p = mkpix(7'h00, 7'h15, 7'h2A, 8'h93, 1'b1, 1'b0, 1'b1, 1'b1);
        step(p, 1'b1, 8'h02, 1'b0);
        vblank(p);
        for (int i = 0; i < 3; i++) step(p, 1'b0, 8'h00, 1'b1);
        total++;
        if (bus.CD !== 10'h115) begin
            bad++;
            $display("FAIL objpri_front: got %h, want 115", bus.CD);
        end
        p.a = 7'h10;
        for (int i = 0; i < 3; i++) step(p, 1'b0, 8'h00, 1'b1);
        total++;
        if (bus.CD !== 10'h393) begin
            bad++;
            $display("FAIL objpri_obj: got %h, want 393", bus.CD);
        end
    endtask

    task automatic test_shadow();
        pix_t p;
        p = mkpix(7'h00, 7'h15, 7'h2A, 8'h93, 1'b0, 1'b1, 1'b1, 1'b1);
        step(p, 1'b1, 8'h04, 1'b0);
        vblank(p);
        for (int i = 0; i < 3; i++) step(p, 1'b0, 8'h00, 1'b1);
        total++;
        if ({bus.CD, bus.SHADOW} !== {10'h115, 1'b1}) begin
            bad++;
            $display("FAIL shadow_on: got cd=%h sh=%b, want cd=115 sh=1", bus.CD, bus.SHADOW);
        end
        p.fix = 7'h7F;
        for (int i = 0; i < 3; i++) step(p, 1'b0, 8'h00, 1'b1);
        total++;
        if ({bus.CD, bus.SHADOW} !== {10'h07F, 1'b0}) begin
            bad++;
            $display("FAIL shadow_fix: got cd=%h sh=%b, want cd=07F sh=0", bus.CD, bus.SHADOW);
        end
    endtask

    task automatic test_write_on_edge();
        pix_t p;
        p = mkpix(7'h00, 7'h15, 7'h2A, 8'h93, 1'b0, 1'b0, 1'b1, 1'b1);
        step(p, 1'b0, 8'h00, 1'b1);
        p.nvblk = 1'b0;
        step(p, 1'b1, 8'h08, 1'b0);
        step(p, 1'b0, 8'h00, 1'b1);
        total++;
        if (bus.CPU_DOUT !== 8'h04) begin
            bad++;
            $display("FAIL edge_this_frame: got %h, want 04", bus.CPU_DOUT);
        end
        p.nvblk = 1'b1;
        for (int i = 0; i < 3; i++) step(p, 1'b0, 8'h00, 1'b1);
        vblank(p);
        total++;
        if (bus.CPU_DOUT !== 8'h08) begin
            bad++;
            $display("FAIL edge_next_frame: got %h, want 08", bus.CPU_DOUT);
        end
    endtask

    task automatic test_blank();
        pix_t p;
        int   zeros;
        int   first;
        p = mkpix(7'h7F, 7'h15, 7'h2A, 8'h93, 1'b0, 1'b0, 1'b1, 1'b1);
        zeros = 0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            p.nhblk = !(i >= 4 && i < 7);
            step(p, 1'b0, 8'h00, 1'b1);
            if (bus.NCBLK === 1'b0) begin
                zeros++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (zeros !== 3 || first !== 5) begin
            bad++;
            $display("FAIL blank_window: got %0d low cycles from step %0d, want 3 from step 5", zeros, first);
        end
    endtask

    task automatic test_reset_mid();
        pix_t p;
        p = mkpix(7'h00, 7'h15, 7'h2A, 8'h93, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(p, 1'b0, 8'h00, 1'b1);
        #2;
        NRESET = 1'b0;
        #1;
        total++;
        if ({bus.CD, bus.SHADOW, bus.NCBLK} !== 12'h000) begin
            bad++;
            $display("FAIL reset_mid: got cd=%h sh=%b ncblk=%b, want 0", bus.CD, bus.SHADOW, bus.NCBLK);
        end
        model_reset();
        @(negedge V6M);
        NRESET = 1'b1;
        for (int i = 0; i < 4; i++) step(p, 1'b0, 8'h00, 1'b1);
        total++;
        if (bus.CD !== 10'h393) begin
            bad++;
            $display("FAIL reset_refill: got %h, want 393", bus.CD);
        end
    endtask

    task automatic test_random();
        pix_t p;
        logic wr;
        for (int i = 0; i < 400; i++) begin
            p.fix   = 7'($urandom_range(0, 127)) & (($urandom_range(0, 3) == 0) ? 7'h7F : 7'h70);
            p.a     = 7'($urandom_range(0, 127));
            p.b     = 7'($urandom_range(0, 127));
            p.obj   = 8'($urandom_range(0, 255));
            p.pri   = 1'($urandom_range(0, 1));
            p.osh   = 1'($urandom_range(0, 1));
            p.nhblk = (i % 10) < 8;
            p.nvblk = (i % 40) < 35;
            wr      = ($urandom_range(0, 15) == 0);
            step(p, wr, 8'($urandom_range(0, 255)), !wr && ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_apply();
        test_objpri();
        test_shadow();
        test_write_on_edge();
        test_blank();
        test_reset_mid();
        test_random();
        step(mkpix(7'h00, 7'h00, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0, 8'h00, 1'b0);
        step(mkpix(7'h00, 7'h00, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0, 8'h00, 1'b0);
        step(mkpix(7'h00, 7'h00, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0, 8'h00, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
